// File: rtl/spi_ctrl_pkg.sv
// Shared types and constants for the SPI register controller.
// Build option SPI_REG_AUTOINC_EN (see spi_reg_controller.sv) selects burst addressing.
package spi_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, CMD, WRITE, READ} spi_ctrl_state_t;

  localparam int CMD_WRITE_BIT  = 7;
  localparam int CMD_ADDR_WIDTH = 7;

  function automatic logic addr_ok(input logic [CMD_ADDR_WIDTH-1:0] addr, input int num_regs);
    return (int'(addr) < num_regs);
  endfunction
endpackage

// File: rtl/spi_ctrl_regfile.sv
// Register bank: one write port, one combinational read port with write-through
// forwarding; out-of-range reads return 0 and out-of-range writes are dropped.
module spi_ctrl_regfile
  import spi_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REGS   = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           i_we,
  input  logic [CMD_ADDR_WIDTH-1:0]      i_waddr,
  input  logic [DATA_WIDTH-1:0]          i_wdata,
  input  logic [CMD_ADDR_WIDTH-1:0]      i_raddr,
  output logic [DATA_WIDTH-1:0]          o_rdata,
  output logic [NUM_REGS*DATA_WIDTH-1:0] o_regs_flat
);
  localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  logic [DATA_WIDTH-1:0] r_mem [NUM_REGS];
  logic                  w_wr_ok;
  logic                  w_rd_ok;

  assign w_wr_ok = i_we && addr_ok(i_waddr, NUM_REGS);
  assign w_rd_ok = addr_ok(i_raddr, NUM_REGS);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) r_mem[i] <= '0;
    end else if (w_wr_ok) begin
      r_mem[i_waddr[AW-1:0]] <= i_wdata;
    end
  end

  always_comb begin
    o_rdata = '0;
    if (w_rd_ok) begin
      if (w_wr_ok && (i_waddr == i_raddr)) o_rdata = i_wdata;
      else                                 o_rdata = r_mem[i_raddr[AW-1:0]];
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign o_regs_flat[g*DATA_WIDTH +: DATA_WIDTH] = r_mem[g];
  end
endmodule

// File: rtl/spi_reg_controller.sv
// Drains the SPI slave receive FIFO, parses a command byte and streams register writes/reads.
// Define SPI_REG_AUTOINC_EN for burst addressing; otherwise the address is fixed per frame.
module spi_reg_controller
  import spi_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REGS   = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           cs,
  input  logic [DATA_WIDTH-1:0]          rx_data,
  input  logic                           rx_empty,
  output logic                           rx_read,
  output logic [DATA_WIDTH-1:0]          tx_data,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_flat,
  output logic                           wr_strobe,
  output logic [CMD_ADDR_WIDTH-1:0]      wr_addr,
  output logic                           frame_error
);
  spi_ctrl_state_t             r_state, w_state_nxt;
  logic                        r_cs_s1, r_cs_s2, r_cs_d;
  logic                        r_rx_read, r_sample, r_drain;
  logic                        r_tx_load, r_frame_error;
  logic [CMD_ADDR_WIDTH-1:0]   r_addr, w_addr_adv, w_raddr;
  logic [DATA_WIDTH-1:0]       r_tx, w_rdata;
  logic [7:0]                  w_cmd;
  logic                        w_cs_fall, w_cs_rise, w_drain, w_we;

  assign w_cmd     = rx_data[7:0];
  assign w_cs_fall = r_cs_d & ~r_cs_s2;
  assign w_cs_rise = ~r_cs_d & r_cs_s2;
  // Return to IDLE only once nothing is queued or in flight from the FIFO.
  assign w_drain   = r_drain && rx_empty && !r_rx_read && !r_sample;

`ifdef SPI_REG_AUTOINC_EN
  assign w_addr_adv = (r_addr == CMD_ADDR_WIDTH'(NUM_REGS-1)) ? '0 : r_addr + 1'b1;
`else
  assign w_addr_adv = r_addr;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cs_s1   <= 1'b1;
      r_cs_s2   <= 1'b1;
      r_cs_d    <= 1'b1;
      r_rx_read <= 1'b0;
      r_sample  <= 1'b0;
      r_drain   <= 1'b0;
      r_state   <= IDLE;
    end else begin
      r_cs_s1   <= cs;
      r_cs_s2   <= r_cs_s1;
      r_cs_d    <= r_cs_s2;
      r_rx_read <= !rx_empty && !r_rx_read;
      r_sample  <= r_rx_read;
      r_state   <= w_state_nxt;
      if (w_cs_rise)    r_drain <= 1'b1;
      else if (w_drain) r_drain <= 1'b0;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_we        = 1'b0;
    w_raddr     = r_addr;
    case (r_state)
      IDLE:  if (w_cs_fall) w_state_nxt = CMD;
      CMD: begin
        w_raddr = w_cmd[CMD_ADDR_WIDTH-1:0];
        if (r_sample) w_state_nxt = w_cmd[CMD_WRITE_BIT] ? WRITE : READ;
      end
      WRITE: w_we = r_sample && addr_ok(r_addr, NUM_REGS);
      default: ;
    endcase
    if (w_drain) w_state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr        <= '0;
      r_tx          <= '0;
      r_tx_load     <= 1'b0;
      r_frame_error <= 1'b0;
    end else begin
      r_tx_load <= 1'b0;
      if (r_tx_load) r_tx <= w_rdata;
      if (r_sample) begin
        case (r_state)
          CMD: begin
            r_addr <= w_cmd[CMD_ADDR_WIDTH-1:0];
            if (!addr_ok(w_cmd[CMD_ADDR_WIDTH-1:0], NUM_REGS)) r_frame_error <= 1'b1;
            if (!w_cmd[CMD_WRITE_BIT]) r_tx <= w_rdata;
          end
          WRITE, READ: begin
            r_addr <= w_addr_adv;
            if (!addr_ok(r_addr, NUM_REGS)) r_frame_error <= 1'b1;
            // Read-back of the advanced address lands one cycle after the dummy byte.
            if (r_state == READ) r_tx_load <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  spi_ctrl_regfile #(.DATA_WIDTH(DATA_WIDTH), .NUM_REGS(NUM_REGS)) u_regfile (
    .clk        (clk),
    .reset      (reset),
    .i_we       (w_we),
    .i_waddr    (r_addr),
    .i_wdata    (rx_data),
    .i_raddr    (w_raddr),
    .o_rdata    (w_rdata),
    .o_regs_flat(regs_flat)
  );

  assign rx_read     = r_rx_read;
  assign tx_data     = r_tx;
  assign wr_strobe   = w_we;
  assign wr_addr     = r_addr;
  assign frame_error = r_frame_error;
endmodule

// File: tb/tb_spi_reg_controller.sv
// Directed bench for spi_reg_controller with a behavioural one-cycle-latency receive FIFO.
module tb_spi_reg_controller;
  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         cs = 1'b1;
  logic [7:0]   rx_data = 8'h00;
  logic         rx_empty;
  logic         rx_read;
  logic [7:0]   tx_data;
  logic [127:0] regs_flat;
  logic         wr_strobe;
  logic [6:0]   wr_addr;
  logic         frame_error;

  int nvec = 0;
  int nmis = 0;

  logic [7:0] mem [0:255];
  int         wp = 0;
  int         rp = 0;
  logic       hold = 1'b0;
  int         scnt = 0;
  int         npop = 0;
  int         consec = 0;
  logic       prev_rd = 1'b0;
  logic [6:0] wlog [0:63];

  spi_reg_controller #(.DATA_WIDTH(8), .NUM_REGS(16)) dut (
    .clk(clk), .reset(reset), .cs(cs), .rx_data(rx_data), .rx_empty(rx_empty),
    .rx_read(rx_read), .tx_data(tx_data), .regs_flat(regs_flat),
    .wr_strobe(wr_strobe), .wr_addr(wr_addr), .frame_error(frame_error)
  );

  always #5 clk = ~clk;

  assign rx_empty = hold ? 1'b0 : (wp == rp);

  always @(posedge clk) begin
    if (rx_read) begin
      if (hold) rx_data <= 8'hE5;
      else if (rp != wp) begin
        rx_data <= mem[rp[7:0]];
        rp      <= rp + 1;
      end
    end
  end

  always @(posedge clk) begin
    if (wr_strobe) begin
      if (scnt < 64) wlog[scnt] <= wr_addr;
      scnt <= scnt + 1;
    end
    if (rx_read) npop <= npop + 1;
    if (rx_read && prev_rd) consec <= consec + 1;
    prev_rd <= rx_read;
  end

  function automatic logic [7:0] rg(input int i);
    return regs_flat[i*8 +: 8];
  endfunction

  task automatic push(input logic [7:0] b);
    int n;
    mem[wp[7:0]] = b;
    wp = wp + 1;
    n = 0;
    while (rp != wp && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (rp != wp) begin
      nvec++; nmis++;
      $display("FAIL fifo_drain: byte %h not popped within 50 cycles", b);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic cs_low;
    cs = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic cs_high;
    cs = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    nvec++; if (tx_data !== 8'h00) begin nmis++; $display("FAIL reset_tx: got %h want 00", tx_data); end
    nvec++; if (rx_read !== 1'b0) begin nmis++; $display("FAIL reset_rx_read: got %b want 0", rx_read); end
    nvec++; if (wr_strobe !== 1'b0 || wr_addr !== 7'd0) begin nmis++; $display("FAIL reset_wr: got %b/%h want 0/00", wr_strobe, wr_addr); end
    nvec++; if (frame_error !== 1'b0) begin nmis++; $display("FAIL reset_fe: got %b want 0", frame_error); end
    nvec++; if (regs_flat !== 128'd0) begin nmis++; $display("FAIL reset_regs: got %h want 0", regs_flat); end
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_burst_write;
    int s0;
    logic [6:0] a1;
    logic [7:0] e2, e3;
`ifdef SPI_REG_AUTOINC_EN
    a1 = 7'd3; e2 = 8'hAA; e3 = 8'hBB;
`else
    a1 = 7'd2; e2 = 8'hBB; e3 = 8'h00;
`endif
    s0 = scnt;
    cs_low();
    push(8'h82); push(8'hAA); push(8'hBB);
    cs_high();
    nvec++; if (scnt - s0 != 2) begin nmis++; $display("FAIL burst_strobes: got %0d want 2", scnt - s0); end
    nvec++; if (wlog[s0] !== 7'd2) begin nmis++; $display("FAIL burst_waddr0: got %h want 02", wlog[s0]); end
    nvec++; if (wlog[s0+1] !== a1) begin nmis++; $display("FAIL burst_waddr1: got %h want %h", wlog[s0+1], a1); end
    nvec++; if (rg(2) !== e2) begin nmis++; $display("FAIL burst_reg2: got %h want %h", rg(2), e2); end
    nvec++; if (rg(3) !== e3) begin nmis++; $display("FAIL burst_reg3: got %h want %h", rg(3), e3); end
  endtask

  task automatic test_read;
    logic [7:0] e1;
`ifdef SPI_REG_AUTOINC_EN
    e1 = 8'h4D;
`else
    e1 = 8'h3C;
`endif
    cs_low(); push(8'h85); push(8'h3C); cs_high();
    cs_low(); push(8'h86); push(8'h4D); cs_high();
    cs_low();
    push(8'h05);
    nvec++; if (tx_data !== 8'h3C) begin nmis++; $display("FAIL read_first: got %h want 3C", tx_data); end
    push(8'h00);
    nvec++; if (tx_data !== e1) begin nmis++; $display("FAIL read_dummy1: got %h want %h", tx_data, e1); end
    cs_high();
    nvec++; if (rg(5) !== 8'h3C || rg(6) !== 8'h4D) begin nmis++; $display("FAIL read_regs_kept: got %h %h want 3C 4D", rg(5), rg(6)); end
  endtask

  task automatic test_wrap;
    logic [7:0] e15, e0;
`ifdef SPI_REG_AUTOINC_EN
    e15 = 8'h11; e0 = 8'h22;
`else
    e15 = 8'h22; e0 = 8'h00;
`endif
    cs_low(); push(8'h8F); push(8'h11); push(8'h22); cs_high();
    nvec++; if (rg(15) !== e15) begin nmis++; $display("FAIL wrap_reg15: got %h want %h", rg(15), e15); end
    nvec++; if (rg(0) !== e0) begin nmis++; $display("FAIL wrap_reg0: got %h want %h", rg(0), e0); end
  endtask

  task automatic test_bad_addr;
    logic [127:0] snap;
    int s0;
    nvec++; if (frame_error !== 1'b0) begin nmis++; $display("FAIL bad_fe_before: got %b want 0", frame_error); end
    snap = regs_flat;
    s0 = scnt;
    cs_low(); push(8'h90); push(8'h55); cs_high();
    nvec++; if (scnt != s0) begin nmis++; $display("FAIL bad_strobe: got %0d pulses want 0", scnt - s0); end
    nvec++; if (regs_flat !== snap) begin nmis++; $display("FAIL bad_bank: got %h want %h", regs_flat, snap); end
    nvec++; if (frame_error !== 1'b1) begin nmis++; $display("FAIL bad_fe: got %b want 1", frame_error); end
  endtask

  task automatic test_reset_mid;
    logic [127:0] exp;
    cs_low(); push(8'h81); push(8'h77);
    nvec++; if (rg(1) !== 8'h77) begin nmis++; $display("FAIL mid_pre_reg1: got %h want 77", rg(1)); end
    mem[wp[7:0]] = 8'hEE;
    wp = wp + 1;
    reset = 1'b1;
    cs = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    nvec++; if (regs_flat !== 128'd0) begin nmis++; $display("FAIL mid_regs: got %h want 0", regs_flat); end
    nvec++; if (frame_error !== 1'b0 || tx_data !== 8'h00) begin nmis++; $display("FAIL mid_outs: got fe=%b tx=%h want 0/00", frame_error, tx_data); end
    nvec++; if (rp != wp) begin nmis++; $display("FAIL mid_residual: got %0d bytes left want 0", wp - rp); end
    cs_low(); push(8'h81); push(8'h99); cs_high();
    exp = '0;
    exp[15:8] = 8'h99;
    nvec++; if (regs_flat !== exp) begin nmis++; $display("FAIL mid_next_frame: got %h want %h", regs_flat, exp); end
  endtask

  task automatic test_handshake;
    logic [127:0] snap;
    int s0, p0, c0;
    snap = regs_flat;
    s0 = scnt; p0 = npop; c0 = consec;
    hold = 1'b1;
    repeat (40) @(negedge clk);
    hold = 1'b0;
    repeat (5) @(negedge clk);
    nvec++; if (consec != c0) begin nmis++; $display("FAIL hs_consecutive: got %0d back-to-back pops want 0", consec - c0); end
    nvec++; if (npop - p0 < 15 || npop - p0 > 21) begin nmis++; $display("FAIL hs_pop_rate: got %0d pops want 15..21", npop - p0); end
    nvec++; if (regs_flat !== snap || scnt != s0) begin nmis++; $display("FAIL hs_no_write: got %h/%0d want %h/0", regs_flat, scnt - s0, snap); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_burst_write();
    test_read();
    test_wrap();
    test_bad_addr();
    test_reset_mid();
    test_handshake();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
